// File: rtl/mult_int8b_pkg.sv
// Shared widths, default coefficient and operand/product types
// for the constant-coefficient signed multiplier.
package mult_int8b_pkg;

    localparam int BIT_WIDTH = 8;
    localparam int OUT_WIDTH = 2 * BIT_WIDTH;

    localparam logic signed [BIT_WIDTH-1:0] DEF_COEFF = 8'sd105;

    typedef logic signed [BIT_WIDTH-1:0] operand_t;
    typedef logic signed [OUT_WIDTH-1:0] product_t;

endpackage

// File: rtl/mult_int8b_array.sv
// Combinational signed partial-product array and adder tree
// computing inp * COEFF at full precision.
module mult_int8b_array
    import mult_int8b_pkg::*;
#(
    parameter int BIT_WIDTH = mult_int8b_pkg::BIT_WIDTH,
    parameter logic signed [BIT_WIDTH-1:0] COEFF = DEF_COEFF
) (
    input  logic signed [BIT_WIDTH-1:0]   inp,
    output logic signed [2*BIT_WIDTH-1:0] prod
);

    localparam int OW = 2 * BIT_WIDTH;
    localparam int LV = $clog2(BIT_WIDTH);
    localparam int NP = 1 << LV;

    logic signed [OW-1:0] ext;

    assign ext = {{(OW-BIT_WIDTH){inp[BIT_WIDTH-1]}}, inp};

    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int N = NP >> l;
        logic signed [OW-1:0] s [N];

        if (l == 0) begin : g_rows
            for (genvar i = 0; i < N; i++) begin : g_row
                if (i >= BIT_WIDTH || COEFF[i] == 1'b0) begin : g_zero
                    assign s[i] = '0;
                end else if (i == BIT_WIDTH - 1) begin : g_neg
                    // Sign row has weight -2^(W-1); negating in OW bits
                    // keeps -128 * -128 from overflowing.
                    assign s[i] = -(ext <<< i);
                end else begin : g_pos
                    assign s[i] = ext <<< i;
                end
            end
        end else begin : g_sum
            for (genvar i = 0; i < N; i++) begin : g_add
                assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
            end
        end
    end

    assign prod = g_lvl[LV].s[0];

endmodule

// File: rtl/mult_int8b_top.sv
// Signed 8-bit by constant multiplier with a registered
// 16-bit product and asynchronous active-low reset.
module mult_int8b_top
    import mult_int8b_pkg::*;
#(
    parameter int BIT_WIDTH = mult_int8b_pkg::BIT_WIDTH,
    parameter int OUT_WIDTH = 2 * BIT_WIDTH,
    parameter logic signed [BIT_WIDTH-1:0] COEFF = DEF_COEFF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [BIT_WIDTH-1:0] inp,
    output logic signed [OUT_WIDTH-1:0] out
);

    logic signed [2*BIT_WIDTH-1:0] prod;

    mult_int8b_array #(
        .BIT_WIDTH (BIT_WIDTH),
        .COEFF     (COEFF)
    ) u_array (
        .inp  (inp),
        .prod (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= OUT_WIDTH'(prod);
        end
    end

endmodule

// File: tb/tb_mult_int8b_top.sv
// Directed and exhaustive checks of the registered constant
// multiplier for COEFF = 105, -128 and 0.
module tb_mult_int8b_top;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [7:0]  inp = '0;
    logic signed [15:0] out_p105;
    logic signed [15:0] out_m128;
    logic signed [15:0] out_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_int8b_top #(.COEFF(8'sd105)) u_p105 (
        .clk   (clk),
        .rst_n (rst_n),
        .inp   (inp),
        .out   (out_p105)
    );

    mult_int8b_top #(.COEFF(-8'sd128)) u_m128 (
        .clk   (clk),
        .rst_n (rst_n),
        .inp   (inp),
        .out   (out_m128)
    );

    mult_int8b_top #(.COEFF(8'sd0)) u_zero (
        .clk   (clk),
        .rst_n (rst_n),
        .inp   (inp),
        .out   (out_zero)
    );

    task automatic chk(input string tag,
                       input logic signed [15:0] got,
                       input logic signed [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (%h), expected %0d (%h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [7:0]  v;
        logic signed [15:0] e;
        logic signed [15:0] bb [4];

        bb[0] = 16'sd105;
        bb[1] = 16'sd210;
        bb[2] = 16'sd315;
        bb[3] = 16'sd420;

        rst_n = 1'b0;
        inp   = 8'h7F;
        #1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_p105", out_p105, 16'sd0);
            chk("rst_m128", out_m128, 16'sd0);
        end

        rst_n = 1'b1;
        inp   = 8'sd3;
        step();
        chk("post_rst", out_p105, 16'sh013B);

        inp = 8'sd127;
        step();
        chk("max_p105", out_p105, 16'sd13335);
        chk("max_m128", out_m128, -16'sd16256);

        inp = -8'sd128;
        step();
        chk("min_p105", out_p105, 16'shCB80);
        chk("min_m128", out_m128, 16'sd16384);

        inp = -8'sd1;
        step();
        chk("neg1_p105", out_p105, 16'shFF97);

        inp = 8'sd0;
        step();
        chk("zero_p105", out_p105, 16'sd0);

        for (int i = 0; i < 4; i++) begin
            inp = 8'(i + 1);
            step();
            chk("b2b", out_p105, bb[i]);
        end

        inp = 8'sd127;
        step();
        chk("pre_arst", out_p105, 16'sd13335);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_p105", out_p105, 16'sd0);
        chk("arst_m128", out_m128, 16'sd0);
        step();
        chk("arst_hold", out_p105, 16'sd0);
        rst_n = 1'b1;
        inp   = 8'sd5;
        step();
        chk("post_arst", out_p105, 16'sd525);

        for (int i = 0; i < 256; i++) begin
            v   = 8'(i);
            inp = v;
            step();
            e = 16'($signed({{8{v[7]}}, v})) * 16'sd105;
            chk("sweep_p105", out_p105, e);
            e = 16'($signed({{8{v[7]}}, v})) * -16'sd128;
            chk("sweep_m128", out_m128, e);
            chk("sweep_zero", out_zero, 16'sd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
